// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and its instruction RAM.
//   state_e        : loader FSM states (CHECK/ERR only reachable with
//                    PROG_LOADER_CHECKSUM_EN defined)
//   DEFAULT_DEPTH  : default program memory size in bytes
//   DEFAULT_AW     : default byte address width
//   NOP_INST       : word presented to the core while it is held in reset
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StRun,
    StErr
  } state_e;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam int unsigned DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/prog_loader_ram.sv
// Byte-wide program memory.
//   clk   : write clock
//   we    : write enable
//   waddr : write byte address
//   wdata : write byte
//   raddr : read byte address (first byte of the word)
//   rdata : {mem[a], mem[a+1], mem[a+2], mem[a+3]}, addresses wrap modulo DEPTH
// Contents are deliberately not reset.
module prog_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // AW-bit additions wrap naturally because DEPTH == 2**AW.
  logic [AW-1:0] a1, a2, a3;
  assign a1 = raddr + AW'(1);
  assign a2 = raddr + AW'(2);
  assign a3 = raddr + AW'(3);

  assign rdata = {mem[raddr], mem[a1], mem[a2], mem[a3]};

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a byte image into prog_ram while holding the core in
// reset, then releases the core and serves big-endian instruction words
// combinationally from the core's byte address.
//   clk, rst_n         : clock, asynchronous active-low reset
//   ld_start           : pulse; begins or restarts a load (wins over a transfer)
//   ld_valid/ld_ready  : byte handshake, ld_data is the byte
//   cpu_add / cpu_inst : core fetch address / instruction (NOP outside RUN)
//   cpu_rst            : active-high core reset, low only in RUN
//   loaded             : high only in RUN
//   err                : checksum failure
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When defined, one extra
// byte after the image must equal the modulo-256 sum of the image bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_add,
  output logic [31:0]   cpu_inst,
  output logic          cpu_rst,
  output logic          loaded,
  output logic          err
);

  localparam logic [AW:0] LastCnt = (AW+1)'(DEPTH - 1);

  state_e      state_q;
  logic [AW:0] cnt_q;
  logic        cpu_rst_q, loaded_q, ld_ready_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic        err_q;
`endif

  logic        mem_we;
  logic [31:0] ram_rdata;

  // ld_ready is high throughout LOAD, so a handshake there is just ld_valid.
  assign mem_we = (state_q == StLoad) && ld_valid && !ld_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cpu_rst_q  <= 1'b1;
      loaded_q   <= 1'b0;
      ld_ready_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else if (ld_start) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      cpu_rst_q  <= 1'b1;
      loaded_q   <= 1'b0;
      ld_ready_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StLoad: begin
          if (ld_valid) begin
            cnt_q <= cnt_q + (AW+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q <= sum_q + ld_data;
`endif
            if (cnt_q == LastCnt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q    <= StCheck;
`else
              state_q    <= StRun;
              cpu_rst_q  <= 1'b0;
              loaded_q   <= 1'b1;
              ld_ready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCheck: begin
          if (ld_valid) begin
            ld_ready_q <= 1'b0;
            if (ld_data == sum_q) begin
              state_q   <= StRun;
              cpu_rst_q <= 1'b0;
              loaded_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: ;  // IDLE, RUN, ERR hold until ld_start
      endcase
    end
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (ld_data),
    .raddr (cpu_add),
    .rdata (ram_rdata)
  );

  // Combinational: the single-cycle core samples this in the same cycle.
  assign cpu_inst = (state_q == StRun) ? ram_rdata : NOP_INST;
  assign cpu_rst  = cpu_rst_q;
  assign loaded   = loaded_q;
  assign ld_ready = ld_ready_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start, ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic [AW-1:0] cpu_add;
  logic [31:0]   cpu_inst;
  logic          cpu_rst, loaded, err;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_add  (cpu_add),
    .cpu_inst (cpu_inst),
    .cpu_rst  (cpu_rst),
    .loaded   (loaded),
    .err      (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_mem [DEPTH];
  bit         m_loading;   // accepting bytes
  int         m_got;       // image bytes accepted since last start
  bit         m_running;
  bit         m_err;
  logic [7:0] m_sum;

  logic [7:0] img [DEPTH];

  function automatic void model_reset();
    m_loading = 0; m_got = 0; m_running = 0; m_err = 0; m_sum = 0;
  endfunction

  function automatic void model_edge(bit s, bit v, logic [7:0] d);
    if (s) begin
      m_loading = 1; m_got = 0; m_running = 0; m_err = 0; m_sum = 0;
    end else if (m_loading && v) begin
      if (m_got < DEPTH) begin
        m_mem[m_got] = d;
        m_sum = m_sum + d;
        m_got++;
`ifndef PROG_LOADER_CHECKSUM_EN
        if (m_got == DEPTH) begin m_loading = 0; m_running = 1; end
`endif
      end else begin
        m_loading = 0;
        if (d == m_sum) m_running = 1;
        else m_err = 1;
      end
    end
  endfunction

  function automatic logic [31:0] model_inst(int a);
    if (!m_running) return 32'h0;
    return {m_mem[a % DEPTH], m_mem[(a + 1) % DEPTH],
            m_mem[(a + 2) % DEPTH], m_mem[(a + 3) % DEPTH]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] inst;
    logic        rst, ld, er, rdy;
    int          addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void push_exp(int a);
    exp_t e;
    e.inst = model_inst(a);
    e.rst  = !m_running;
    e.ld   = m_running;
    e.er   = m_err;
    e.rdy  = m_loading;
    e.addr = a;
    exp_q.push_back(e);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] want, int a);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s @%0t addr=%0d: got %h expected %h", name, $time, a, act, want);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("cpu_inst", cpu_inst, e.inst, e.addr);
      cmp("cpu_rst", {31'b0, cpu_rst}, {31'b0, e.rst}, e.addr);
      cmp("loaded", {31'b0, loaded}, {31'b0, e.ld}, e.addr);
      cmp("err", {31'b0, err}, {31'b0, e.er}, e.addr);
      cmp("ld_ready", {31'b0, ld_ready}, {31'b0, e.rdy}, e.addr);
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1: drive, record expectation, advance one edge.
  task automatic step(bit s, bit v, logic [7:0] d, int a);
    ld_start = s; ld_valid = v; ld_data = d; cpu_add = AW'(a);
    push_exp(a);
    @(posedge clk);
    if (rst_n) model_edge(s, v, d);
    #1;
  endtask

  function automatic int raddr();
    return int'($urandom_range(DEPTH - 1, 0));
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  task automatic fill_img();
    for (int i = 0; i < DEPTH; i++) img[i] = rbyte();
    img[0] = 8'h10; img[1] = 8'h00; img[2] = 8'h01; img[3] = 8'h00;
    img[62] = 8'hAA; img[63] = 8'hBB;
  endtask

  // Start pulse (with a simultaneous valid byte that must be discarded),
  // then the image, then the checksum byte when that feature is built in.
  task automatic load_image(bit gaps, bit bad_sum);
    logic [7:0] sum;
    int sent;
    sum = 0;
    for (int i = 0; i < DEPTH; i++) sum = sum + img[i];
    step(1, 1, rbyte(), raddr());
    sent = 0;
    for (int c = 0; c < 4 * DEPTH && sent < DEPTH; c++) begin
      bit v;
      v = gaps ? c[0] : 1'b1;
      step(0, v, v ? img[sent] : rbyte(), raddr());
      if (v) sent++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    step(0, 1, bad_sum ? sum + 8'd1 : sum, raddr());
`else
    if (bad_sum) sum = 0;
`endif
  endtask

  task automatic run_fetches();
    step(0, 0, 0, 0);
    step(0, 0, 0, 62);
    step(0, 0, 0, 63);
    for (int i = 0; i < 6; i++) step(0, $urandom_range(1, 0) == 1, rbyte(), raddr());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    model_reset();
    rst_n = 0; ld_start = 0; ld_valid = 0; ld_data = 0; cpu_add = 0;
    #1;
    // Reset values while rst_n is low.
    for (int i = 0; i < 3; i++) step(0, 1, rbyte(), raddr());
    rst_n = 1;
    // Idle: ld_valid ignored.
    for (int i = 0; i < 4; i++) step(0, 1, rbyte(), raddr());

    // Back-to-back load, then fetch (incl. address 0 and wrap at 62).
    fill_img();
    load_image(0, 0);
    run_fetches();

    // Gapped load; cpu_inst must stay 0 until the last handshake.
    fill_img();
    load_image(1, 0);
    run_fetches();

    // Restart after 20 bytes: start coincides with a valid byte.
    fill_img();
    step(1, 0, 0, raddr());
    for (int i = 0; i < 20; i++) step(0, 1, rbyte(), raddr());
    load_image(0, 0);
    run_fetches();
    // ld_start in RUN drops the core back into reset next cycle.
    step(1, 0, 0, raddr());
    step(0, 0, 0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum, then a correct reload.
    fill_img();
    load_image(0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, rbyte(), raddr());
    load_image(0, 0);
    run_fetches();
`endif

    // Asynchronous reset in the middle of a load (after byte 30).
    fill_img();
    step(1, 0, 0, raddr());
    for (int i = 0; i < 30; i++) step(0, 1, img[i], raddr());
    ld_valid = 1;
    rst_n = 0;
    #1;
    model_reset();
    push_exp(int'(cpu_add));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) step(0, 1, rbyte(), raddr());
    rst_n = 1;
    for (int i = 0; i < 4; i++) step(0, 1, rbyte(), raddr());
    fill_img();
    load_image(0, 0);
    run_fetches();

    // Random traffic with occasional restarts.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99, 0) == 0, $urandom_range(3, 0) != 0, rbyte(), raddr());
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
